// File: rtl/home_pkg.sv
// Shared home-automation types: controller FSM states, keypad digit constants
// and the factory default access code used by the comfort and lighting blocks.
package home_pkg;

  localparam int HOME_DIGIT_W  = 4;
  localparam int BCD_MAX       = 9;
  localparam int HOME_CODE_LEN = 4;

  // First digit sits in the most significant nibble.
  localparam logic [HOME_CODE_LEN*HOME_DIGIT_W-1:0] HOME_DEFAULT_CODE = 16'h1234;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_GRANTED,
    ST_LOCKOUT
  } state_e;

endpackage

// File: rtl/pass_timer.sv
// Loadable down-counter with a zero flag; used for the session and lockout timers.
module pass_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  // Load wins over decrement; the count parks at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/pass_gate.sv
// Keypad authentication front-end: collects a digit code, checks it against the
// stored code, holds pass_check for a bounded session and locks out after failures.
module pass_gate
  import home_pkg::*;
#(
  parameter int CODE_LEN       = HOME_CODE_LEN,
  parameter int DIGIT_W        = HOME_DIGIT_W,
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 1000,
  parameter int SESSION_CYCLES = 5000,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = HOME_DEFAULT_CODE
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             key_valid,
  input  logic [DIGIT_W-1:0]               key_digit,
  input  logic                             key_enter,
  input  logic                             key_clear,
  input  logic                             logout,
  input  logic                             code_we,
  output logic                             pass_check,
  output logic                             locked,
  output logic                             fail_pulse,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic [$clog2(CODE_LEN+1)-1:0]    digit_cnt,
  output logic [2:0]                       state_dbg
);

  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int SES_W  = $clog2(SESSION_CYCLES);
  localparam int LCK_W  = $clog2(LOCK_CYCLES);

  // Keypad strobes are single-cycle pulses with no back-pressure: each one is
  // either consumed or dropped in the cycle it is high (priority: logout,
  // key_clear, key_enter, key_valid).
  state_e             state_q, state_d;
  logic [CODE_W-1:0]  entry_q, entry_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic               fail_q, fail_d;
  logic               armed_q, armed_d;
  logic               ses_load, ses_zero;
  logic               lck_load, lck_zero;
  logic               digit_ok;
  logic               entry_match;

  assign digit_ok    = key_valid && (key_digit <= DIGIT_W'(BCD_MAX)) &&
                       (cnt_q < CNT_W'(CODE_LEN));
  assign entry_match = (cnt_q == CNT_W'(CODE_LEN)) && (entry_q == code_q);

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    cnt_d    = cnt_q;
    tries_d  = tries_q;
    code_d   = code_q;
    armed_d  = armed_q;
    fail_d   = 1'b0;
    ses_load = 1'b0;
    lck_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_clear) begin
          state_d = ST_IDLE;
        end else if (key_enter) begin
          state_d = ST_CHECK;
        end else if (digit_ok) begin
          entry_d = {entry_q[CODE_W-DIGIT_W-1:0], key_digit};
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (key_clear) begin
          entry_d = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (key_enter) begin
          state_d = ST_CHECK;
        end else if (digit_ok) begin
          entry_d = {entry_q[CODE_W-DIGIT_W-1:0], key_digit};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        if (entry_match) begin
          tries_d  = TRY_W'(MAX_TRIES);
          ses_load = 1'b1;
          state_d  = ST_GRANTED;
        end else begin
          fail_d  = 1'b1;
          tries_d = (tries_q == '0) ? '0 : tries_q - TRY_W'(1);
          if (tries_q <= TRY_W'(1)) begin
            lck_load = 1'b1;
            state_d  = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GRANTED: begin
        ses_load = key_valid;
        if (logout) begin
          entry_d = '0;
          cnt_d   = '0;
          armed_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (key_clear) begin
            entry_d = '0;
            cnt_d   = '0;
            armed_d = 1'b0;
          end else if (key_enter) begin
            // Only a complete entry replaces the code; a short one just aborts.
            if (armed_q && (cnt_q == CNT_W'(CODE_LEN))) begin
              code_d   = entry_q;
              ses_load = 1'b1;
            end
            entry_d = '0;
            cnt_d   = '0;
            armed_d = 1'b0;
          end else if (code_we) begin
            entry_d = '0;
            cnt_d   = '0;
            armed_d = 1'b1;
          end else if (armed_q && digit_ok) begin
            entry_d = {entry_q[CODE_W-DIGIT_W-1:0], key_digit};
            cnt_d   = cnt_q + CNT_W'(1);
          end
          if (ses_zero && !ses_load) begin
            entry_d = '0;
            cnt_d   = '0;
            armed_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOCKOUT: begin
        if (lck_zero) begin
          tries_d = TRY_W'(MAX_TRIES);
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      entry_q <= '0;
      cnt_q   <= '0;
      tries_q <= TRY_W'(MAX_TRIES);
      code_q  <= DEFAULT_CODE;
      armed_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      code_q  <= code_d;
      armed_q <= armed_d;
      fail_q  <= fail_d;
    end
  end

  pass_timer #(.W(SES_W)) u_session_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ses_load),
    .load_val_i (SES_W'(SESSION_CYCLES - 1)),
    .dec_i      (state_q == ST_GRANTED),
    .zero_o     (ses_zero)
  );

  pass_timer #(.W(LCK_W)) u_lock_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lck_load),
    .load_val_i (LCK_W'(LOCK_CYCLES - 1)),
    .dec_i      (state_q == ST_LOCKOUT),
    .zero_o     (lck_zero)
  );

  assign pass_check = (state_q == ST_GRANTED);
  assign locked     = (state_q == ST_LOCKOUT);
  assign fail_pulse = fail_q;
  assign tries_left = tries_q;
  assign digit_cnt  = cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pass_gate.sv
// Directed and randomized bench for pass_gate against a digit-queue reference model.
module tb_pass_gate;

  localparam int MAX_TRIES   = 3;
  localparam int LOCK_LEN    = 1000;
  localparam int SESSION_LEN = 5000;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_enter;
  logic       key_clear;
  logic       logout;
  logic       code_we;
  logic       pass_check;
  logic       locked;
  logic       fail_pulse;
  logic [1:0] tries_left;
  logic [2:0] digit_cnt;
  logic [2:0] state_dbg;

  pass_gate dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .key_enter  (key_enter),
    .key_clear  (key_clear),
    .logout     (logout),
    .code_we    (code_we),
    .pass_check (pass_check),
    .locked     (locked),
    .fail_pulse (fail_pulse),
    .tries_left (tries_left),
    .digit_cnt  (digit_cnt),
    .state_dbg  (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int last_outcome_cyc = 0;

  // Reference model: stored code and typed digits as plain integer lists.
  int m_code[4];
  int m_entry[$];
  int m_tries;
  bit m_granted;
  bit m_locked;
  bit m_armed;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_match();
    if (m_entry.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_entry[i] != m_code[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_key(input int d);
    if (m_locked) return;
    if (m_granted && !m_armed) return;
    if (d <= 9 && m_entry.size() < 4) m_entry.push_back(d);
  endfunction

  // Driver tasks
  task automatic do_reset();
    rst_n = 1'b0; key_valid = 1'b0; key_digit = '0; key_enter = 1'b0;
    key_clear = 1'b0; logout = 1'b0; code_we = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    m_code = '{1, 2, 3, 4};
    m_entry.delete();
    m_tries = MAX_TRIES; m_granted = 1'b0; m_locked = 1'b0; m_armed = 1'b0;
  endtask

  task automatic press(input int d);
    key_valid = 1'b1;
    key_digit = 4'(d);
    tick();
    key_valid = 1'b0;
    model_key(d);
    check("digit_cnt", 32'(digit_cnt), 32'(m_entry.size()));
  endtask

  task automatic submit(input string tag, input int extra);
    bit ok;
    ok = model_match();
    key_enter = 1'b1;
    if (extra >= 0) begin
      key_valid = 1'b1;
      key_digit = 4'(extra);
    end
    tick();
    key_enter = 1'b0;
    key_valid = 1'b0;
    check({tag, ":pc_during_check"}, 32'(pass_check), 32'd0);
    tick();
    last_outcome_cyc = cyc;
    m_entry.delete();
    if (ok) begin
      m_tries = MAX_TRIES;
      m_granted = 1'b1;
    end else begin
      if (m_tries > 0) m_tries--;
      if (m_tries == 0) m_locked = 1'b1;
    end
    check({tag, ":pass_check"}, 32'(pass_check), 32'(ok));
    check({tag, ":fail_pulse"}, 32'(fail_pulse), 32'(!ok));
    check({tag, ":tries_left"}, 32'(tries_left), 32'(m_tries));
    check({tag, ":locked"}, 32'(locked), 32'(m_locked));
    check({tag, ":cnt_cleared"}, 32'(digit_cnt), 32'd0);
    if (!ok) begin
      tick();
      check({tag, ":fail_pulse_len"}, 32'(fail_pulse), 32'd0);
    end
  endtask

  task automatic press_code(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic logout_step(input string tag);
    logout = 1'b1;
    tick();
    logout = 1'b0;
    m_granted = 1'b0; m_armed = 1'b0; m_entry.delete();
    check({tag, ":pass_check"}, 32'(pass_check), 32'd0);
  endtask

  task automatic clear_step(input string tag);
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    m_entry.delete();
    if (m_granted) m_armed = 1'b0;
    check({tag, ":digit_cnt"}, 32'(digit_cnt), 32'd0);
  endtask

  task automatic arm_step();
    code_we = 1'b1;
    tick();
    code_we = 1'b0;
    m_armed = 1'b1;
    m_entry.delete();
  endtask

  task automatic commit(input string tag);
    if (m_entry.size() == 4) begin
      for (int i = 0; i < 4; i++) m_code[i] = m_entry[i];
    end
    key_enter = 1'b1;
    tick();
    key_enter = 1'b0;
    m_entry.delete();
    m_armed = 1'b0;
    check({tag, ":pass_check"}, 32'(pass_check), 32'd1);
    check({tag, ":digit_cnt"}, 32'(digit_cnt), 32'd0);
  endtask

  task automatic wait_unlock(input string tag);
    for (int i = 0; i < 2 * LOCK_LEN && locked; i++) tick();
    check({tag, ":lock_len"}, 32'(cyc - last_outcome_cyc), 32'(LOCK_LEN));
    check({tag, ":locked"}, 32'(locked), 32'd0);
    check({tag, ":tries_left"}, 32'(tries_left), 32'(MAX_TRIES));
    m_locked = 1'b0;
    m_tries = MAX_TRIES;
  endtask

  task automatic wait_session_end(input string tag, input int exp_len);
    int g;
    g = last_outcome_cyc;
    for (int i = 0; i < 3 * SESSION_LEN && pass_check; i++) tick();
    check({tag, ":session_len"}, 32'(cyc - g), 32'(exp_len));
    check({tag, ":digit_cnt"}, 32'(digit_cnt), 32'd0);
    m_granted = 1'b0;
    m_armed = 1'b0;
  endtask

  // Scripted sequence
  initial begin
    int g;
    do_reset();
    check("rst:pass_check", 32'(pass_check), 32'd0);
    check("rst:locked", 32'(locked), 32'd0);
    check("rst:fail_pulse", 32'(fail_pulse), 32'd0);
    check("rst:tries_left", 32'(tries_left), 32'(MAX_TRIES));
    check("rst:digit_cnt", 32'(digit_cnt), 32'd0);

    press_code(1, 2, 3, 4);
    submit("good_code", -1);
    logout_step("logout");

    for (int k = 0; k < 3; k++) begin
      press_code(9, 9, 9, 9);
      submit("wrong_code", -1);
    end
    press(5);
    check("lock:still_locked", 32'(locked), 32'd1);
    wait_unlock("lockout");

    press(1); press(2); press(10); press(3);
    submit("short_entry", -1);
    press(4); press(5);
    clear_step("mid_clear");

    press_code(1, 2, 3, 4);
    press(7);
    submit("over_length", -1);
    wait_session_end("timeout", SESSION_LEN);

    press_code(1, 2, 3, 4);
    submit("regrant", -1);
    g = last_outcome_cyc;
    repeat (4000) tick();
    press(3);
    while (cyc < g + SESSION_LEN) tick();
    check("extend:still_granted", 32'(pass_check), 32'd1);
    wait_session_end("extend", 4000 + SESSION_LEN + 1);

    press_code(1, 2, 3, 4);
    submit("chg_login", -1);
    arm_step();
    press_code(5, 6, 7, 8);
    commit("chg_write");
    logout_step("chg_logout");
    press_code(1, 2, 3, 4);
    submit("old_code", -1);
    press_code(5, 6, 7, 8);
    submit("new_code", -1);
    arm_step();
    press(1); press(1);
    commit("chg_abort");
    logout_step("abort_logout");
    press_code(5, 6, 7, 8);
    submit("kept_code", -1);
    logout_step("kept_logout");

    do_reset();
    press_code(1, 2, 3, 4);
    submit("after_reset", -1);
    logout_step("reset_logout");

    press_code(1, 2, 3, 4);
    submit("simultaneous", 9);
    logout_step("simul_logout");

    submit("idle_enter", -1);

    for (int it = 0; it < 24; it++) begin
      int n;
      n = int'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 5) == 0) press(int'($urandom_range(10, 15)));
          press(m_code[i]);
        end
        for (int i = 0; i < n; i++) press(int'($urandom_range(0, 9)));
      end else begin
        for (int i = 0; i < n; i++) press(int'($urandom_range(0, 15)));
        if ($urandom_range(0, 3) == 0) clear_step("rnd_clear");
      end
      submit("rnd", -1);
      if (m_granted) logout_step("rnd_logout");
      if (m_locked) wait_unlock("rnd_unlock");
    end

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pass_gate.md
Name: pass_gate

Overview:
- Keypad authentication front-end for the home-automation controller; generates the pass_check level that enables the comfort system.
- Collects a fixed-length digit code from the keypad, compares it against a stored code, and holds pass_check high for a bounded session.
- Locks out entry after repeated failures.
- Supports changing the stored code while a session is active.

Parameters:
- CODE_LEN, 4, number of digits in a code
- DIGIT_W, 4, bits per keypad digit (BCD 0-9; values above 9 are rejected)
- MAX_TRIES, 3, consecutive failures before lockout
- LOCK_CYCLES, 1000, lockout duration in clk cycles
- SESSION_CYCLES, 5000, pass_check hold time without keypad activity
- DEFAULT_CODE, 16'h1234, stored code after reset (CODE_LEN*DIGIT_W bits, first digit in the MSBs)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- key_valid  in  1  one-cycle strobe; key_digit is valid this cycle
- key_digit  in  DIGIT_W  digit value
- key_enter  in  1  one-cycle strobe; submit the entered digits
- key_clear  in  1  one-cycle strobe; discard the partial entry
- logout  in  1  one-cycle strobe; end the session
- code_we  in  1  one-cycle strobe; while GRANTED, the next full entry replaces the stored code
- pass_check  out  1  high while authenticated; drives the comfort system
- locked  out  1  high during lockout
- fail_pulse  out  1  one-cycle pulse on each rejected entry
- tries_left  out  2  remaining attempts before lockout
- digit_cnt  out  3  digits entered so far

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the clk rising edge.
- Reset values: pass_check=0, locked=0, fail_pulse=0, tries_left=MAX_TRIES, digit_cnt=0, stored code=DEFAULT_CODE, state=IDLE.
- States and transitions:
  - IDLE: first valid digit -> ENTRY.
  - ENTRY: accumulates digits; key_enter -> CHECK.
  - CHECK: one cycle; compares the entry with the stored code.
    - Match -> GRANTED.
    - Mismatch with tries_left > 1 -> IDLE.
    - Mismatch with tries_left = 1 -> LOCKOUT.
  - GRANTED: pass_check=1.
  - LOCKOUT: locked=1; all keypad strobes ignored.
- Digit shifting: each key_valid with key_digit<=9 and digit_cnt<CODE_LEN shifts the digit into the entry register and increments digit_cnt.
  - Digit >9: ignored, no count change.
  - Digit beyond CODE_LEN: ignored (no wrap, no overwrite).
- key_enter with digit_cnt != CODE_LEN is a failure, handled exactly like a mismatch.
- Entry register and digit_cnt clear on entering CHECK's successor state, on key_clear, and on reset.
- Failure: fail_pulse is high for exactly the cycle after CHECK and tries_left decrements.
- Success: tries_left reloads to MAX_TRIES. pass_check rises the cycle after CHECK, so the latency from the key_enter edge to pass_check=1 is 2 cycles.
- GRANTED session control:
  - A session timer loads SESSION_CYCLES-1 on entry to GRANTED and on any key_valid.
  - It decrements every cycle; at 0 -> IDLE, pass_check=0 on the next cycle.
  - logout -> IDLE immediately; pass_check is 0 the cycle after the logout strobe.
- Code change in GRANTED:
  - code_we arms a change.
  - Subsequent digits fill the entry register; key_enter with digit_cnt==CODE_LEN writes the stored code and disarms. The session stays GRANTED and the timer reloads.
  - An incomplete entry aborts the change with no write.
  - key_clear disarms.
- LOCKOUT: a counter runs LOCK_CYCLES cycles, then -> IDLE with locked=0 and tries_left=MAX_TRIES.
- Simultaneous events, highest priority first:
  - rst_n low > logout > key_clear > key_enter > key_valid.
  - A key_valid coincident with key_enter is dropped.
  - In IDLE, key_enter alone counts as a failed attempt.
- Reset mid-operation: any state returns to IDLE and the stored code reverts to DEFAULT_CODE. Code changes are not retained across reset.
- Width rules:
  - Counters are sized by $clog2 of their limits.
  - tries_left saturates at 0.
  - Comparison is full-width equality.

Decomposition:
- Shared package home_pkg holds:
  - the state enum (IDLE, ENTRY, CHECK, GRANTED, LOCKOUT);
  - the digit width and BCD_MAX=9 constants;
  - the default code constant, so the comfort and lighting blocks share the same types.
- One sub-module: pass_timer. It is a loadable down-counter with a zero flag, instantiated twice (session and lockout).

Test Plan:
- Correct code: enter 1,2,3,4 then enter -> pass_check=1 two cycles after the enter strobe; tries_left=3.
- Three wrong codes: 9,9,9,9 + enter three times -> fail_pulse x3; tries_left 2,1,0; locked=1. Digits during lockout are ignored. After 1000 cycles locked=0, tries_left=3.
- Short entry and invalid digit: digits 1,2,A,3 + enter -> A ignored, digit_cnt=3, treated as a failure, tries_left=2. Key_clear mid-entry -> digit_cnt=0.
- Session timeout and logout: grant, then idle 5000 cycles -> pass_check falls at cycle 5000. Re-grant, keypress at cycle 4000 -> timeout extended. Logout -> pass_check=0 next cycle.
- Code change: grant, code_we, 5,6,7,8 + enter, logout. Then 1,2,3,4 fails and 5,6,7,8 grants. Assert reset -> 1,2,3,4 grants again.
- Simultaneity: key_valid and key_enter in the same cycle with 4 digits stored -> the digit is dropped and the check uses the 4 stored digits.
